// File: rtl/ilkn_metaframe_tx.sv
// ilkn_metaframe_tx
//   Interlaken lane framer. Builds metaframes of META_FRAME_LEN words:
//   sync, scrambler state, skip, payload/idle slots, then a diagnostic word.
//   Output words are paced by a fractional accumulator (PACE_NUM/PACE_DEN)
//   that models the gearbox consuming fewer words than there are clocks.
//
//   Optional feature macro: ILKN_DIAG_CRC32_EN
//     defined   -> CRC-32C (0x1EDC6F41, MSB first, init all-ones) over every
//                  emitted 64-bit word of the metaframe, starting with the sync
//                  word. The diagnostic word is folded in with its CRC field
//                  zeroed, and the inverted result is placed in that field.
//     undefined -> CRC field is zero, no CRC logic.
//
// Ports
//   USER_CLK        clock, rising edge
//   SYSTEM_RESET    synchronous active-high reset
//   DATA_IN         user payload word
//   DATA_TO_SEND    DATA_IN is valid
//   DATA_IN_READY   combinational: this cycle is a payload slot
//                   (word transfers when DATA_TO_SEND && DATA_IN_READY)
//   SCRAM_STATE_IN  scrambler state, sampled in the scrambler-state slot
//   LANE_STATUS     sampled in the diagnostic slot
//   LINK_STATUS     sampled in the diagnostic slot
//   DATA_OUT        registered 64-bit word
//   HEADER_OUT      registered header (01 data, 10 control)
//   DATA_VALID      registered, a new word is on DATA_OUT this cycle
//   FRAME_START     registered, DATA_OUT is the sync word

module ilkn_metaframe_tx #(
    parameter int META_FRAME_LEN = 16,
    parameter int PACE_NUM       = 64,
    parameter int PACE_DEN       = 67
) (
    input  logic        USER_CLK,
    input  logic        SYSTEM_RESET,
    input  logic [63:0] DATA_IN,
    input  logic        DATA_TO_SEND,
    output logic        DATA_IN_READY,
    input  logic [57:0] SCRAM_STATE_IN,
    input  logic        LANE_STATUS,
    input  logic        LINK_STATUS,
    output logic [63:0] DATA_OUT,
    output logic [1:0]  HEADER_OUT,
    output logic        DATA_VALID,
    output logic        FRAME_START
);

    // One extra bit so acc + PACE_NUM (< 2*PACE_DEN) never overflows.
    localparam int AW = $clog2(PACE_DEN) + 1;
    localparam int PW = $clog2(META_FRAME_LEN);

    localparam logic [AW-1:0] ACC_NUM  = AW'(PACE_NUM);
    localparam logic [AW-1:0] ACC_DEN  = AW'(PACE_DEN);
    localparam logic [AW-1:0] ACC_RST  = AW'(PACE_DEN - PACE_NUM);

    localparam logic [PW-1:0] POS_LAST   = PW'(META_FRAME_LEN - 1);
    localparam logic [PW-1:0] POS_PAY_HI = PW'(META_FRAME_LEN - 2);
    localparam logic [PW-1:0] POS_PAY_LO = PW'(3);

    localparam logic [63:0] SYNC_WORD = 64'h78F678F678F678F6;
    localparam logic [63:0] SKIP_WORD = 64'h1E1E1E1E1E1E1E1E;
    localparam logic [63:0] IDLE_WORD = 64'hAAAAAAAAAAAAAAAA;

    logic [AW-1:0] r_acc;
    logic [PW-1:0] r_pos;
    logic [63:0]   r_data;
    logic [1:0]    r_hdr;
    logic          r_valid;
    logic          r_fs;

    logic [AW-1:0] w_acc_sum;
    logic [AW-1:0] w_acc_next;
    logic          w_slot;
    logic          w_pay_pos;
    logic          w_diag_pos;
    logic [63:0]   w_word_raw;   // word with the CRC field still zero
    logic [63:0]   w_word;
    logic [1:0]    w_hdr;
    logic [31:0]   w_crc_field;

    // Reset cycles are never slots, so the first cycle out of reset sees
    // acc + NUM == DEN and is guaranteed to emit the sync word.
    assign w_acc_sum  = r_acc + ACC_NUM;
    assign w_slot     = !SYSTEM_RESET && (w_acc_sum >= ACC_DEN);
    assign w_acc_next = w_slot ? (w_acc_sum - ACC_DEN) : w_acc_sum;

    assign w_pay_pos     = (r_pos >= POS_PAY_LO) && (r_pos <= POS_PAY_HI);
    assign w_diag_pos    = (r_pos == POS_LAST);
    assign DATA_IN_READY = w_slot && w_pay_pos;

    always_comb begin
        w_word_raw = IDLE_WORD;
        w_hdr      = 2'b10;
        if (r_pos == PW'(0)) begin
            w_word_raw = SYNC_WORD;
        end else if (r_pos == PW'(1)) begin
            w_word_raw = {6'b001010, SCRAM_STATE_IN};
        end else if (r_pos == PW'(2)) begin
            w_word_raw = SKIP_WORD;
        end else if (w_diag_pos) begin
            w_word_raw = {6'b011001, 24'h0, LANE_STATUS, LINK_STATUS, 32'h0};
        end else if (DATA_TO_SEND) begin
            w_word_raw = DATA_IN;
            w_hdr      = 2'b01;
        end
    end

`ifdef ILKN_DIAG_CRC32_EN
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY = 32'h1EDC6F41;

    function automatic logic [31:0] crc32c_step(input logic [31:0] c,
                                                input logic [63:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 63; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ CRC_POLY;
        end
        return r;
    endfunction

    logic [31:0] r_crc;
    logic [31:0] w_crc_seed;
    logic [31:0] w_crc_upd;

    // The sync slot reseeds from init, so a metaframe abandoned by reset or a
    // stale register never leaks into the next one.
    assign w_crc_seed  = (r_pos == PW'(0)) ? CRC_INIT : r_crc;
    assign w_crc_upd   = crc32c_step(w_crc_seed, w_word_raw);
    assign w_crc_field = ~w_crc_upd;

    always_ff @(posedge USER_CLK) begin
        if (SYSTEM_RESET) begin
            r_crc <= CRC_INIT;
        end else if (w_slot) begin
            r_crc <= w_crc_upd;
        end
    end
`else
    assign w_crc_field = 32'h0;
`endif

    assign w_word = w_diag_pos ? (w_word_raw | {32'h0, w_crc_field}) : w_word_raw;

    always_ff @(posedge USER_CLK) begin
        if (SYSTEM_RESET) begin
            r_acc   <= ACC_RST;
            r_pos   <= '0;
            r_data  <= '0;
            r_hdr   <= 2'b00;
            r_valid <= 1'b0;
            r_fs    <= 1'b0;
        end else begin
            r_acc   <= w_acc_next;
            r_valid <= w_slot;
            r_fs    <= w_slot && (r_pos == PW'(0));
            if (w_slot) begin
                r_data <= w_word;
                r_hdr  <= w_hdr;
                r_pos  <= w_diag_pos ? '0 : r_pos + PW'(1);
            end
        end
    end

    assign DATA_OUT    = r_data;
    assign HEADER_OUT  = r_hdr;
    assign DATA_VALID  = r_valid;
    assign FRAME_START = r_fs;

endmodule

// File: tb/tb_ilkn_metaframe_tx.sv
// Testbench for ilkn_metaframe_tx. Instance dut_a uses default parameters;
// instance dut_b uses META_FRAME_LEN=5 with a slot on every cycle.
module tb_ilkn_metaframe_tx;

    localparam logic [63:0] SYNC_W = 64'h78F678F678F678F6;
    localparam logic [63:0] SKIP_W = 64'h1E1E1E1E1E1E1E1E;
    localparam logic [63:0] IDLE_W = 64'hAAAAAAAAAAAAAAAA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---- instance A (defaults)
    logic        rst_a = 1'b1;
    logic [63:0] din_a = '0;
    logic        dts_a = 1'b0;
    logic        rdy_a;
    logic [57:0] scram_a = '0;
    logic        lane_a = 1'b0;
    logic        link_a = 1'b0;
    logic [63:0] dout_a;
    logic [1:0]  hdr_a;
    logic        dv_a;
    logic        fs_a;

    // ---- instance B (LEN 5, full rate)
    logic        rst_b = 1'b1;
    logic [63:0] din_b = '0;
    logic        dts_b = 1'b0;
    logic        rdy_b;
    logic [57:0] scram_b = '0;
    logic        lane_b = 1'b0;
    logic        link_b = 1'b0;
    logic [63:0] dout_b;
    logic [1:0]  hdr_b;
    logic        dv_b;
    logic        fs_b;

    ilkn_metaframe_tx dut_a (
        .USER_CLK(clk), .SYSTEM_RESET(rst_a), .DATA_IN(din_a),
        .DATA_TO_SEND(dts_a), .DATA_IN_READY(rdy_a), .SCRAM_STATE_IN(scram_a),
        .LANE_STATUS(lane_a), .LINK_STATUS(link_a), .DATA_OUT(dout_a),
        .HEADER_OUT(hdr_a), .DATA_VALID(dv_a), .FRAME_START(fs_a)
    );

    ilkn_metaframe_tx #(.META_FRAME_LEN(5), .PACE_NUM(67), .PACE_DEN(67)) dut_b (
        .USER_CLK(clk), .SYSTEM_RESET(rst_b), .DATA_IN(din_b),
        .DATA_TO_SEND(dts_b), .DATA_IN_READY(rdy_b), .SCRAM_STATE_IN(scram_b),
        .LANE_STATUS(lane_b), .LINK_STATUS(link_b), .DATA_OUT(dout_b),
        .HEADER_OUT(hdr_b), .DATA_VALID(dv_b), .FRAME_START(fs_b)
    );

    int n_pass  = 0;
    int n_total = 0;
    logic [63:0] exp_q[$];

    // Software CRC-32C reference, MSB first, non-reflected.
    function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [63:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 63; i >= 0; i--) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h1EDC6F41;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    // ---- driver tasks
    task automatic reset_a();
        @(negedge clk);
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
    endtask

    task automatic reset_b();
        @(negedge clk);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
    endtask

    // ---- tests
    task automatic test_reset();
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (dout_a !== 64'h0) $display("FAIL reset_data: got %h want 0", dout_a); else n_pass++;
        n_total++; if (hdr_a !== 2'b00) $display("FAIL reset_hdr: got %b want 00", hdr_a); else n_pass++;
        n_total++; if (dv_a !== 1'b0) $display("FAIL reset_valid: got %b want 0", dv_a); else n_pass++;
        n_total++; if (fs_a !== 1'b0) $display("FAIL reset_fs: got %b want 0", fs_a); else n_pass++;
        n_total++; if (rdy_a !== 1'b0) $display("FAIL reset_ready: got %b want 0", rdy_a); else n_pass++;
    endtask

    // Idle metaframes: framing words, idle fill, diag fields, ready pattern.
    task automatic test_idle_frame();
        int k, cyc, slot;
        logic prev_rdy;
        logic [63:0] ew;
        logic [31:0] crc;
        lane_a  = 1'b1;
        link_a  = 1'b0;
        scram_a = 58'h2AB_CDEF0123_4567;
        dts_a   = 1'b0;
        reset_a();
        k = 0; cyc = 0; crc = 32'hFFFFFFFF;
        prev_rdy = rdy_a;
        while (k < 32 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc <= 3) begin
                n_total++;
                if (dv_a !== (cyc != 2)) $display("FAIL idle_slot_pattern c%0d: got %b want %b", cyc, dv_a, (cyc != 2));
                else n_pass++;
            end
            if (dv_a === 1'b1) begin
                slot = k % 16;
                case (slot)
                    0:       ew = SYNC_W;
                    1:       ew = 64'h2AABCDEF01234567;
                    2:       ew = SKIP_W;
                    15:      ew = 64'h6400000200000000;
                    default: ew = IDLE_W;
                endcase
                if (slot == 0) crc = crc_model(32'hFFFFFFFF, ew);
                else           crc = crc_model(crc, ew);
`ifdef ILKN_DIAG_CRC32_EN
                if (slot == 15) ew = ew | {32'h0, ~crc};
`endif
                n_total++; if (dout_a !== ew) $display("FAIL idle_word k%0d: got %h want %h", k, dout_a, ew); else n_pass++;
                n_total++; if (hdr_a !== 2'b10) $display("FAIL idle_hdr k%0d: got %b want 10", k, hdr_a); else n_pass++;
                n_total++; if (fs_a !== (slot == 0)) $display("FAIL idle_fs k%0d: got %b want %b", k, fs_a, (slot == 0)); else n_pass++;
                n_total++;
                if (prev_rdy !== (slot >= 3 && slot <= 14)) $display("FAIL idle_ready k%0d: got %b want %b", k, prev_rdy, (slot >= 3 && slot <= 14));
                else n_pass++;
                k++;
            end else begin
                n_total++; if (prev_rdy !== 1'b0) $display("FAIL gap_ready c%0d: got %b want 0", cyc, prev_rdy); else n_pass++;
                n_total++; if (fs_a !== 1'b0) $display("FAIL gap_fs c%0d: got %b want 0", cyc, fs_a); else n_pass++;
            end
            prev_rdy = rdy_a;
        end
        n_total++; if (k != 32) $display("FAIL idle_timeout: got %0d words want 32", k); else n_pass++;
    endtask

    // Continuous payload: 12 words per metaframe, in order, none lost.
    task automatic test_payload();
        int k, cyc, slot, n_pay;
        logic prev_rdy;
        logic [63:0] ew;
        dts_a = 1'b1;
        din_a = 64'h1;
        exp_q.delete();
        reset_a();
        k = 0; cyc = 0; n_pay = 0;
        prev_rdy = rdy_a;
        if (prev_rdy) exp_q.push_back(din_a);
        while (k < 32 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (dv_a === 1'b1) begin
                slot = k % 16;
                n_total++;
                if (prev_rdy !== (slot >= 3 && slot <= 14)) $display("FAIL pay_ready k%0d: got %b want %b", k, prev_rdy, (slot >= 3 && slot <= 14));
                else n_pass++;
                if (slot >= 3 && slot <= 14) begin
                    ew = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
                    n_pay++;
                    n_total++; if (dout_a !== ew) $display("FAIL pay_word k%0d: got %h want %h", k, dout_a, ew); else n_pass++;
                    n_total++; if (hdr_a !== 2'b01) $display("FAIL pay_hdr k%0d: got %b want 01", k, hdr_a); else n_pass++;
                end else begin
                    n_total++; if (hdr_a !== 2'b10) $display("FAIL pay_ctl_hdr k%0d: got %b want 10", k, hdr_a); else n_pass++;
                end
                k++;
            end else begin
                n_total++; if (prev_rdy !== 1'b0) $display("FAIL pay_gap_ready c%0d: got %b want 0", cyc, prev_rdy); else n_pass++;
            end
            if (prev_rdy) din_a = din_a + 64'h1;
            prev_rdy = rdy_a;
            if (prev_rdy) exp_q.push_back(din_a);
        end
        n_total++; if (n_pay != 24) $display("FAIL pay_count: got %0d want 24", n_pay); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL pay_leftover: got %0d want 0", exp_q.size()); else n_pass++;
        dts_a = 1'b0;
    endtask

    task automatic test_rate();
        int cnt;
        reset_a();
        cnt = 0;
        repeat (670) begin
            @(negedge clk);
            if (dv_a === 1'b1) cnt++;
        end
        n_total++; if (cnt != 640) $display("FAIL rate_64_67: got %0d want 640", cnt); else n_pass++;
    endtask

    task automatic test_mid_reset();
        int k, cyc;
        dts_a = 1'b0;
        reset_a();
        k = 0; cyc = 0;
        while (k < 7 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (dv_a === 1'b1) k++;
        end
        n_total++; if (k != 7) $display("FAIL midrst_timeout: got %0d want 7", k); else n_pass++;
        rst_a = 1'b1;
        @(negedge clk);
        n_total++; if (dout_a !== 64'h0) $display("FAIL midrst_data: got %h want 0", dout_a); else n_pass++;
        n_total++; if (hdr_a !== 2'b00) $display("FAIL midrst_hdr: got %b want 00", hdr_a); else n_pass++;
        n_total++; if (dv_a !== 1'b0) $display("FAIL midrst_valid: got %b want 0", dv_a); else n_pass++;
        n_total++; if (fs_a !== 1'b0) $display("FAIL midrst_fs: got %b want 0", fs_a); else n_pass++;
        rst_a = 1'b0;
        @(negedge clk);
        n_total++; if (dv_a !== 1'b1) $display("FAIL midrst_resync_valid: got %b want 1", dv_a); else n_pass++;
        n_total++; if (fs_a !== 1'b1) $display("FAIL midrst_resync_fs: got %b want 1", fs_a); else n_pass++;
        n_total++; if (dout_a !== SYNC_W) $display("FAIL midrst_resync_word: got %h want %h", dout_a, SYNC_W); else n_pass++;
        n_total++; if (hdr_a !== 2'b10) $display("FAIL midrst_resync_hdr: got %b want 10", hdr_a); else n_pass++;
    endtask

    // Short metaframe at full rate: valid every cycle, CRC field check.
    task automatic test_full_rate_crc();
        int slot;
        logic [63:0] ew;
        logic [1:0]  eh;
        logic [31:0] crc;
        scram_b = 58'h0;
        lane_b  = 1'b0;
        link_b  = 1'b1;
        din_b   = 64'h0123456789ABCDEF;
        dts_b   = 1'b1;
        reset_b();
        crc = 32'hFFFFFFFF;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            slot = c % 5;
            eh = 2'b10;
            case (slot)
                0:       ew = SYNC_W;
                1:       ew = 64'h2800000000000000;
                2:       ew = SKIP_W;
                3:       begin ew = 64'h0123456789ABCDEF; eh = 2'b01; end
                default: ew = 64'h6400000100000000;
            endcase
            if (slot == 0) crc = crc_model(32'hFFFFFFFF, ew);
            else           crc = crc_model(crc, ew);
`ifdef ILKN_DIAG_CRC32_EN
            if (slot == 4) ew = ew | {32'h0, ~crc};
`endif
            n_total++; if (dv_b !== 1'b1) $display("FAIL full_valid c%0d: got %b want 1", c, dv_b); else n_pass++;
            n_total++; if (dout_b !== ew) $display("FAIL full_word c%0d: got %h want %h", c, dout_b, ew); else n_pass++;
            n_total++; if (hdr_b !== eh) $display("FAIL full_hdr c%0d: got %b want %b", c, hdr_b, eh); else n_pass++;
            n_total++; if (fs_b !== (slot == 0)) $display("FAIL full_fs c%0d: got %b want %b", c, fs_b, (slot == 0)); else n_pass++;
        end
        dts_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_frame();
        test_payload();
        test_rate();
        test_mid_reset();
        test_full_rate_crc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ilkn_metaframe_tx.md
# ilkn_metaframe_tx

Parametrised Interlaken lane framer, successor to the fixed 16-word transmit interface. It builds complete metaframes: sync, scrambler state, skip, payload/idle and diagnostic words with an optional CRC-32C. Words go out as 64-bit data plus 2-bit header, paced by a programmable gearbox rate. It sits between the user packet source and the lane scrambler/gearbox.

## Interface
- META_FRAME_LEN, 16: words per metaframe including 4 framing words; legal range 5..8192.
- PACE_NUM, 64: gearbox bits accepted per clock; 1 <= PACE_NUM <= PACE_DEN.
- PACE_DEN, 67: bits per transmitted word (64 data + header + scrambler overhead).

Ports:
- USER_CLK  in  1  clock; all logic on rising edge.
- SYSTEM_RESET  in  1  synchronous, active-high reset.
- DATA_IN  in  64  user payload word.
- DATA_TO_SEND  in  1  DATA_IN holds a valid payload word.
- DATA_IN_READY  out  1  combinational; current cycle is a payload slot. A word transfers when DATA_TO_SEND && DATA_IN_READY.
- SCRAM_STATE_IN  in  58  scrambler state; sampled in the scrambler-state slot.
- LANE_STATUS  in  1  sampled in the diagnostic slot.
- LINK_STATUS  in  1  sampled in the diagnostic slot.
- DATA_OUT  out  64  registered word.
- HEADER_OUT  out  2  registered header: 2'b01 data, 2'b10 control.
- DATA_VALID  out  1  registered; DATA_OUT/HEADER_OUT carry a new word this cycle.
- FRAME_START  out  1  registered; high together with DATA_VALID when DATA_OUT is the sync word.

## Operation
- Pacing accumulator `acc`, width clog2(PACE_DEN)+1, reset value PACE_DEN-PACE_NUM.
  - Every non-reset cycle: `slot = (acc+PACE_NUM >= PACE_DEN)`.
  - acc <= slot ? acc+PACE_NUM-PACE_DEN : acc+PACE_NUM.
  - Defaults give 64 slots per 67 cycles. PACE_NUM==PACE_DEN gives a slot every cycle.
- Position counter `pos`, 0..META_FRAME_LEN-1, reset 0. Advances only on a slot and wraps to 0 after META_FRAME_LEN-1.
- Word chosen on a slot, by pos (all framing words use header 2'b10):
  - pos 0, sync: 64'h78F678F678F678F6.
  - pos 1, scrambler state: {6'b001010, SCRAM_STATE_IN}.
  - pos 2, skip: 64'h1E1E1E1E1E1E1E1E.
  - pos 3..LEN-2, payload: if DATA_TO_SEND, {2'b01, DATA_IN}; else idle {2'b10, 64'hAAAAAAAAAAAAAAAA}.
  - pos LEN-1, diagnostic: {6'b011001, 24'h0, LANE_STATUS, LINK_STATUS, crc_field}.
- DATA_IN_READY = slot && (3 <= pos <= LEN-2). It is never high in framing slots, non-slot cycles or reset.
- DATA_TO_SEND is ignored whenever DATA_IN_READY is low; no word is consumed.
- When there is no slot, DATA_OUT/HEADER_OUT hold their previous value and DATA_VALID is 0.
- Reset, including mid-metaframe: DATA_OUT=0, HEADER_OUT=2'b00, DATA_VALID=0, FRAME_START=0, pos=0, acc=reset value, CRC=init. The partial metaframe is abandoned.

## Timing
- Decision cycle t (slot, pos) → DATA_OUT/HEADER_OUT/DATA_VALID valid at cycle t+1. Latency is 1 clock.
- The first cycle with SYSTEM_RESET low is always a slot. The sync word appears one cycle later with DATA_VALID=1 and FRAME_START=1.
- With defaults, the slot pattern after reset is: 1 slot, 1 gap, then slots/gaps following the accumulator (64 of every 67 cycles).
- SCRAM_STATE_IN, LANE_STATUS, LINK_STATUS and DATA_IN are sampled only on the decision cycle.

## Configuration
- Macro ILKN_DIAG_CRC32_EN.
  - Defined: CRC-32C is computed over all emitted words of the metaframe.
    - Polynomial 0x1EDC6F41, MSB-first, non-reflected, 64 bits per slot, init 32'hFFFFFFFF.
    - The diagnostic word is included with its CRC field zeroed.
    - crc_field = final value inverted.
    - The CRC resets to init when the sync word is emitted and on reset.
  - Undefined: crc_field = 32'h0 and no CRC logic is synthesised.

## Test plan
- Reset release, defaults, DATA_TO_SEND=0 → cycle 1: DATA_VALID=1, FRAME_START=1, {10, 78F678F678F678F6}. Then scrambler state, skip, 12 idles and the diagnostic word, repeating every 16 slots.
- DATA_TO_SEND held 1, DATA_IN incrementing from 64'h1 → exactly 12 accepted words per metaframe, each output {01, value} in order with none lost or duplicated. DATA_IN_READY is low in pos 0,1,2,15 and in gap cycles.
- PACE_NUM=64, PACE_DEN=67 over 670 cycles → exactly 640 DATA_VALID pulses. PACE_NUM=PACE_DEN → DATA_VALID on every cycle.
- SCRAM_STATE_IN=58'h2AB_CDEF0123_4567, LANE_STATUS=1, LINK_STATUS=0 → scrambler word 64'h2AABCDEF01234567. Diagnostic word bits [33:32]=2'b10.
- SYSTEM_RESET pulsed at pos 7 → outputs zero next cycle; the next word is the sync word with FRAME_START=1.
- With ILKN_DIAG_CRC32_EN, META_FRAME_LEN=5 and a fixed payload of 64'h0123456789ABCDEF → diagnostic CRC field matches the software CRC-32C model. Without the macro, the field is 32'h0.
